// File: rtl/reduction_lut_bank.sv
// Run-time loadable LUT bank for modular-square reduction: one table per channel,
// paired into dual-port memories, streamed in by the host through a load handshake.
module reduction_lut_bank #(
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NONREDUNDANT_ELEMENTS = 64,
    parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
    parameter int WORD_LEN              = 16,
    parameter int BIT_LEN               = 17,
    parameter int ADDR_LEN              = 9,
    parameter int ELEMS_PER_ROM         = 2,
    parameter int OUT_REG               = 1,
    parameter int INIT_FROM_FILE        = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 lookup_valid,
    output logic                                                 lookup_ready,
    input  logic [NUM_ELEMENTS-1:0][ADDR_LEN-1:0]                lookup_addr,
    output logic                                                 lookup_drop,
    output logic                                                 lut_valid,
    output logic [NUM_ELEMENTS-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] lut_data,
    input  logic                                                 load_start,
    input  logic                                                 load_valid,
    output logic                                                 load_ready,
    input  logic [WORD_LEN*NONREDUNDANT_ELEMENTS-1:0]            load_data,
    output logic                                                 table_ok
);
    // state   | meaning
    // IDLE    | serving lookups when table_ok is set
    // LOADING | accepting load beats, lookups rejected

    localparam int DEPTH       = 2**ADDR_LEN;
    localparam int DW          = WORD_LEN * NONREDUNDANT_ELEMENTS;
    localparam int NUM_ROMS    = (NUM_ELEMENTS + ELEMS_PER_ROM - 1) / ELEMS_PER_ROM;
    localparam int NUM_PORTS   = NUM_ROMS * ELEMS_PER_ROM;
    localparam int ROM_AW      = $clog2(ELEMS_PER_ROM * DEPTH);
    localparam int TOTAL_BEATS = NUM_ELEMENTS * DEPTH;
    localparam int CNT_W       = $clog2(TOTAL_BEATS) + 1;
    localparam int CH_W        = CNT_W - ADDR_LEN;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL_BEATS - 1);

    typedef enum logic {IDLE, LOADING} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  table_ok_q, table_ok_d;
    logic                  lookup_fire, beat, rd_valid_q;
    logic [CH_W-1:0]       wr_chan;
    logic [ADDR_LEN-1:0]   wr_entry;
    logic [ADDR_LEN-1:0]   addr_pad [NUM_PORTS];
    logic [DW-1:0]         rd_word  [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] fmt;

    assign lookup_ready = table_ok_q && (state_q == IDLE);
    assign load_ready   = (state_q == LOADING);
    assign table_ok     = table_ok_q;
    assign lookup_fire  = lookup_valid && lookup_ready;
    // A beat coinciding with a restart is discarded so the new stream starts clean.
    assign beat         = load_valid && load_ready && !load_start;
    assign wr_chan      = cnt_q[CNT_W-1:ADDR_LEN];
    assign wr_entry     = cnt_q[ADDR_LEN-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        table_ok_d = table_ok_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOADING;
                    cnt_d      = '0;
                    table_ok_d = 1'b0;
                end
            end
            LOADING: begin
                if (load_start) begin
                    cnt_d = '0;
                end else if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        table_ok_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            table_ok_q  <= (INIT_FROM_FILE != 0);
            lookup_drop <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            table_ok_q  <= table_ok_d;
            lookup_drop <= lookup_valid && !lookup_ready;
            rd_valid_q  <= lookup_fire;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            addr_pad[k] = '0;
            if (k < NUM_ELEMENTS) addr_pad[k] = lookup_addr[k];
        end
    end

    function automatic logic [ROM_AW-1:0] port_addr(input int p, input logic [ADDR_LEN-1:0] a);
        return ROM_AW'(p * DEPTH) + ROM_AW'(a);
    endfunction

    for (genvar r = 0; r < NUM_ROMS; r++) begin : g_rom
        logic [DW-1:0] mem  [ELEMS_PER_ROM*DEPTH];
        logic [DW-1:0] rd_q [ELEMS_PER_ROM];

        // Each channel owns one port: writes come from the loader, reads from lookups.
        always_ff @(posedge clk) begin
            for (int p = 0; p < ELEMS_PER_ROM; p++) begin
                if (r * ELEMS_PER_ROM + p < NUM_ELEMENTS) begin
                    if (beat && (int'(wr_chan) == r * ELEMS_PER_ROM + p))
                        mem[port_addr(p, wr_entry)] <= load_data;
                    if (lookup_fire)
                        rd_q[p] <= mem[port_addr(p, addr_pad[r*ELEMS_PER_ROM+p])];
                end
            end
        end

        for (genvar p = 0; p < ELEMS_PER_ROM; p++) begin : g_port
            if (r * ELEMS_PER_ROM + p < NUM_ELEMENTS) begin : g_used
                assign rd_word[r*ELEMS_PER_ROM+p] = rd_q[p];
            end
        end
    end

    always_comb begin
        fmt = '0;
        for (int k = 0; k < NUM_ELEMENTS; k++)
            for (int l = 0; l < NONREDUNDANT_ELEMENTS; l++)
                fmt[k][l] = BIT_LEN'(rd_word[k][l*WORD_LEN +: WORD_LEN]);
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic lut_valid_q;
        logic [NUM_ELEMENTS-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] lut_data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lut_valid_q <= 1'b0;
                lut_data_q  <= '0;
            end else begin
                lut_valid_q <= rd_valid_q;
                if (rd_valid_q) lut_data_q <= fmt;
            end
        end
        assign lut_valid = lut_valid_q;
        assign lut_data  = lut_data_q;
    end else begin : g_out_comb
        assign lut_valid = rd_valid_q;
        assign lut_data  = fmt;
    end

    a_no_port_clash: assert property (@(posedge clk) disable iff (!rst_n) !(beat && lookup_fire));

endmodule
